// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
//   Groups the decode-side instruction bus, the pipeline control
//   (hold/flush), the EX/MEM and MEM/WB forwarding producers and the
//   EX-side operand outputs of the operand stage.
//   master : decode/back-end side (drives id_*, hold, flush, fw_*)
//   slave  : the operand stage (drives ex_*, id_stall)
interface ex_operand_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [31:0] id_csr_data;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [4:0]  id_alu_op;
  logic        id_b_sel;
  logic        id_reg_write;
  logic        id_mem_read;

  logic        hold;
  logic        flush;

  logic [4:0]  fw_mem_rd;
  logic        fw_mem_we;
  logic [31:0] fw_mem_data;
  logic [4:0]  fw_wb_rd;
  logic        fw_wb_we;
  logic [31:0] fw_wb_data;

  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [31:0] ex_pc;
  logic [31:0] ex_csr_data;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_alu_op;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [31:0] ex_store_data;
  logic        id_stall;

  modport master (
    output id_valid, id_pc, id_imm, id_csr_data, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_alu_op, id_b_sel, id_reg_write,
           id_mem_read, hold, flush,
           fw_mem_rd, fw_mem_we, fw_mem_data, fw_wb_rd, fw_wb_we, fw_wb_data,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_pc, ex_csr_data, ex_rd,
           ex_alu_op, ex_alu_a, ex_alu_b, ex_store_data, id_stall
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_csr_data, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_alu_op, id_b_sel, id_reg_write,
           id_mem_read, hold, flush,
           fw_mem_rd, fw_mem_we, fw_mem_data, fw_wb_rd, fw_wb_we, fw_wb_data,
    output ex_valid, ex_reg_write, ex_mem_read, ex_pc, ex_csr_data, ex_rd,
           ex_alu_op, ex_alu_a, ex_alu_b, ex_store_data, id_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register with operand forwarding and load-use
//   hazard detection. Outputs are combinational from the stage register
//   and the live forwarding producers.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears the stage register
//   bus : ex_operand_stage_if.slave (decode inputs, hold/flush, forwarding
//         producers, EX operands, id_stall)
module ex_operand_stage (
  input  logic                  clk,
  input  logic                  rst,
  ex_operand_stage_if.slave     bus
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [31:0] r_csr_data;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [4:0]  r_alu_op;
  logic        r_b_sel;
  logic        r_reg_write;
  logic        r_mem_read;

  logic        w_load_use;
  logic        w_wb_id_rs1;
  logic        w_wb_id_rs2;
  logic        w_wb_ex_rs1;
  logic        w_wb_ex_rs2;
  logic        w_mem_ex_rs1;
  logic        w_mem_ex_rs2;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;

  assign w_load_use = bus.id_valid & r_valid & r_mem_read & (r_rd != 5'd0) &
                      ((r_rd == bus.id_rs1) | (r_rd == bus.id_rs2));

  // Register x0 is never bypassed, whichever producer claims it.
  assign w_wb_id_rs1  = bus.fw_wb_we  & (bus.fw_wb_rd  != 5'd0) & (bus.fw_wb_rd  == bus.id_rs1);
  assign w_wb_id_rs2  = bus.fw_wb_we  & (bus.fw_wb_rd  != 5'd0) & (bus.fw_wb_rd  == bus.id_rs2);
  assign w_wb_ex_rs1  = bus.fw_wb_we  & (bus.fw_wb_rd  != 5'd0) & (bus.fw_wb_rd  == r_rs1);
  assign w_wb_ex_rs2  = bus.fw_wb_we  & (bus.fw_wb_rd  != 5'd0) & (bus.fw_wb_rd  == r_rs2);
  assign w_mem_ex_rs1 = bus.fw_mem_we & (bus.fw_mem_rd != 5'd0) & (bus.fw_mem_rd == r_rs1);
  assign w_mem_ex_rs2 = bus.fw_mem_we & (bus.fw_mem_rd != 5'd0) & (bus.fw_mem_rd == r_rs2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_csr_data  <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_alu_op    <= '0;
      r_b_sel     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (bus.flush || (!bus.hold && w_load_use)) begin
      // Flush and the load-use bubble both insert the same all-zero nop.
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_csr_data  <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_alu_op    <= '0;
      r_b_sel     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (bus.hold) begin
      // While frozen, the register file may still retire a write to one of
      // our sources; capture it so the value survives the WB producer moving on.
      if (w_wb_ex_rs1) r_rs1_data <= bus.fw_wb_data;
      if (w_wb_ex_rs2) r_rs2_data <= bus.fw_wb_data;
    end else begin
      r_valid     <= bus.id_valid;
      r_pc        <= bus.id_pc;
      r_imm       <= bus.id_imm;
      r_csr_data  <= bus.id_csr_data;
      r_rs1       <= bus.id_rs1;
      r_rs2       <= bus.id_rs2;
      r_rd        <= bus.id_rd;
      r_rs1_data  <= w_wb_id_rs1 ? bus.fw_wb_data : bus.id_rs1_data;
      r_rs2_data  <= w_wb_id_rs2 ? bus.fw_wb_data : bus.id_rs2_data;
      r_alu_op    <= bus.id_alu_op;
      r_b_sel     <= bus.id_b_sel;
      r_reg_write <= bus.id_reg_write;
      r_mem_read  <= bus.id_mem_read;
    end
  end

  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (w_mem_ex_rs1)     w_fwd_rs1 = bus.fw_mem_data;
    else if (w_wb_ex_rs1) w_fwd_rs1 = bus.fw_wb_data;

    w_fwd_rs2 = r_rs2_data;
    if (w_mem_ex_rs2)     w_fwd_rs2 = bus.fw_mem_data;
    else if (w_wb_ex_rs2) w_fwd_rs2 = bus.fw_wb_data;
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_reg_write  = r_valid & r_reg_write;
  assign bus.ex_mem_read   = r_valid & r_mem_read;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_csr_data   = r_csr_data;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_alu_a      = w_fwd_rs1;
  assign bus.ex_alu_b      = r_b_sel ? r_imm : w_fwd_rs2;
  assign bus.ex_store_data = w_fwd_rs2;
  assign bus.id_stall      = bus.hold | w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_operand_stage_if bus_if ();

  ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference view of the instruction currently sitting in EX.
  typedef struct packed {
    logic        v;
    logic [31:0] pc, imm, csr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2;
    logic [4:0]  op;
    logic        bsel, rw, mr;
  } ex_t;

  ex_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic wb_hits(input logic [4:0] idx);
    return bus_if.fw_wb_we && idx != 5'd0 && bus_if.fw_wb_rd == idx;
  endfunction

  function automatic logic mem_hits(input logic [4:0] idx);
    return bus_if.fw_mem_we && idx != 5'd0 && bus_if.fw_mem_rd == idx;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] stored);
    if (mem_hits(idx)) return bus_if.fw_mem_data;
    if (wb_hits(idx))  return bus_if.fw_wb_data;
    return stored;
  endfunction

  function automatic logic hazard();
    return bus_if.id_valid && m.v && m.mr && m.rd != 5'd0 &&
           (m.rd == bus_if.id_rs1 || m.rd == bus_if.id_rs2);
  endfunction

  task automatic check_all();
    #1;
    chk("ex_valid",      bus_if.ex_valid,      m.v);
    chk("ex_reg_write",  bus_if.ex_reg_write,  m.v && m.rw);
    chk("ex_mem_read",   bus_if.ex_mem_read,   m.v && m.mr);
    chk("ex_pc",         bus_if.ex_pc,         m.pc);
    chk("ex_csr_data",   bus_if.ex_csr_data,   m.csr);
    chk("ex_rd",         bus_if.ex_rd,         m.rd);
    chk("ex_alu_op",     bus_if.ex_alu_op,     m.op);
    chk("ex_alu_a",      bus_if.ex_alu_a,      operand(m.rs1, m.d1));
    chk("ex_alu_b",      bus_if.ex_alu_b,      m.bsel ? m.imm : operand(m.rs2, m.d2));
    chk("ex_store_data", bus_if.ex_store_data, operand(m.rs2, m.d2));
    chk("id_stall",      bus_if.id_stall,      bus_if.hold || hazard());
  endtask

  // Advance one rising edge, applying the stage's update rules to the model.
  task automatic cycle();
    ex_t nxt;
    @(posedge clk);
    nxt = m;
    if (bus_if.flush || (!bus_if.hold && hazard())) begin
      nxt = '0;
    end else if (bus_if.hold) begin
      if (wb_hits(m.rs1)) nxt.d1 = bus_if.fw_wb_data;
      if (wb_hits(m.rs2)) nxt.d2 = bus_if.fw_wb_data;
    end else begin
      nxt.v    = bus_if.id_valid;
      nxt.pc   = bus_if.id_pc;
      nxt.imm  = bus_if.id_imm;
      nxt.csr  = bus_if.id_csr_data;
      nxt.rs1  = bus_if.id_rs1;
      nxt.rs2  = bus_if.id_rs2;
      nxt.rd   = bus_if.id_rd;
      nxt.d1   = wb_hits(bus_if.id_rs1) ? bus_if.fw_wb_data : bus_if.id_rs1_data;
      nxt.d2   = wb_hits(bus_if.id_rs2) ? bus_if.fw_wb_data : bus_if.id_rs2_data;
      nxt.op   = bus_if.id_alu_op;
      nxt.bsel = bus_if.id_b_sel;
      nxt.rw   = bus_if.id_reg_write;
      nxt.mr   = bus_if.id_mem_read;
    end
    m = nxt;
    #1;
  endtask

  task automatic idle();
    bus_if.id_valid = 0; bus_if.id_pc = '0; bus_if.id_imm = '0; bus_if.id_csr_data = '0;
    bus_if.id_rs1 = '0; bus_if.id_rs2 = '0; bus_if.id_rd = '0;
    bus_if.id_rs1_data = '0; bus_if.id_rs2_data = '0; bus_if.id_alu_op = '0;
    bus_if.id_b_sel = 0; bus_if.id_reg_write = 0; bus_if.id_mem_read = 0;
    bus_if.hold = 0; bus_if.flush = 0;
    bus_if.fw_mem_rd = '0; bus_if.fw_mem_we = 0; bus_if.fw_mem_data = '0;
    bus_if.fw_wb_rd = '0; bus_if.fw_wb_we = 0; bus_if.fw_wb_data = '0;
  endtask

  task automatic present(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [31:0] imm,
                         input logic bsel, input logic mr);
    bus_if.id_valid = 1; bus_if.id_pc = 32'h100 + 32'(rd); bus_if.id_csr_data = 32'hC0 + 32'(rs1);
    bus_if.id_rs1 = rs1; bus_if.id_rs1_data = d1; bus_if.id_rs2 = rs2; bus_if.id_rs2_data = d2;
    bus_if.id_rd = rd; bus_if.id_imm = imm; bus_if.id_b_sel = bsel;
    bus_if.id_alu_op = 5'd1; bus_if.id_reg_write = 1; bus_if.id_mem_read = mr;
  endtask

  initial begin
    m = '0;
    idle();
    rst = 1;
    #2;
    check_all();
    chk("reset_valid", bus_if.ex_valid, 1'b0);
    rst = 0;

    // Basic load with immediate on B.
    present(5'd3, 32'd5, 5'd0, 32'd0, 5'd4, 32'd7, 1'b1, 1'b0);
    cycle();
    idle();
    check_all();
    chk("load_alu_a", bus_if.ex_alu_a, 32'd5);
    chk("load_alu_b", bus_if.ex_alu_b, 32'd7);
    chk("load_rd",    bus_if.ex_rd,    5'd4);

    // Forwarding priority on rs1=x2 holding 0x11.
    present(5'd2, 32'h11, 5'd2, 32'h22, 5'd9, 32'h0, 1'b0, 1'b0);
    cycle();
    idle();
    bus_if.hold = 1;
    bus_if.fw_mem_rd = 5'd2; bus_if.fw_mem_we = 1; bus_if.fw_mem_data = 32'hAA;
    bus_if.fw_wb_rd  = 5'd2; bus_if.fw_wb_we  = 1; bus_if.fw_wb_data  = 32'hBB;
    check_all();
    chk("fwd_mem", bus_if.ex_alu_a, 32'hAA);
    bus_if.fw_mem_we = 0;
    check_all();
    chk("fwd_wb", bus_if.ex_alu_a, 32'hBB);
    bus_if.fw_mem_we = 1; bus_if.fw_mem_rd = '0; bus_if.fw_wb_rd = '0;
    check_all();
    chk("fwd_none", bus_if.ex_alu_a, 32'h11);
    idle();

    // Load-use: load x5 in EX, consumer reads x5 as rs2.
    present(5'd1, 32'h1, 5'd0, 32'h0, 5'd5, 32'h4, 1'b1, 1'b1);
    cycle();
    present(5'd7, 32'h70, 5'd5, 32'h50, 5'd8, 32'h0, 1'b0, 1'b0);
    check_all();
    chk("lu_stall", bus_if.id_stall, 1'b1);
    cycle();
    check_all();
    chk("lu_bubble_valid", bus_if.ex_valid, 1'b0);
    chk("lu_bubble_rw",    bus_if.ex_reg_write, 1'b0);
    chk("lu_stall_once",   bus_if.id_stall, 1'b0);
    cycle();
    idle();
    check_all();
    chk("lu_loaded_rd", bus_if.ex_rd, 5'd8);

    // Hold for three cycles while WB writes x6.
    present(5'd6, 32'h12, 5'd0, 32'h0, 5'd10, 32'h0, 1'b0, 1'b0);
    cycle();
    idle();
    bus_if.hold = 1;
    bus_if.fw_wb_rd = 5'd6; bus_if.fw_wb_we = 1; bus_if.fw_wb_data = 32'h55;
    present(5'd11, 32'h3, 5'd12, 32'h4, 5'd13, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_all();
      chk("hold_stall", bus_if.id_stall, 1'b1);
      cycle();
      chk("hold_rd", bus_if.ex_rd, 5'd10);
    end
    idle();
    check_all();
    chk("hold_release_a", bus_if.ex_alu_a, 32'h55);

    // Flush wins over hold.
    bus_if.hold = 1; bus_if.flush = 1;
    cycle();
    idle();
    check_all();
    chk("flush_valid", bus_if.ex_valid, 1'b0);

    // Same-cycle register-file write/read bypass.
    present(5'd6, 32'h01, 5'd0, 32'h0, 5'd14, 32'h0, 1'b0, 1'b0);
    bus_if.fw_wb_rd = 5'd6; bus_if.fw_wb_we = 1; bus_if.fw_wb_data = 32'h99;
    cycle();
    idle();
    check_all();
    chk("rf_bypass", bus_if.ex_alu_a, 32'h99);

    // Asynchronous reset in the middle of a hold.
    bus_if.hold = 1;
    cycle();
    rst = 1;
    m = '0;
    check_all();
    chk("async_rst_pc", bus_if.ex_pc, 32'h0);
    chk("async_rst_stall", bus_if.id_stall, 1'b1);
    rst = 0;
    idle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bus_if.id_valid     = ($urandom_range(0, 3) != 0);
      bus_if.id_pc        = $urandom;
      bus_if.id_imm       = $urandom;
      bus_if.id_csr_data  = $urandom;
      bus_if.id_rs1       = 5'($urandom_range(0, 7));
      bus_if.id_rs2       = 5'($urandom_range(0, 7));
      bus_if.id_rd        = 5'($urandom_range(0, 7));
      bus_if.id_rs1_data  = $urandom;
      bus_if.id_rs2_data  = $urandom;
      bus_if.id_alu_op    = 5'($urandom_range(0, 31));
      bus_if.id_b_sel     = 1'($urandom_range(0, 1));
      bus_if.id_reg_write = 1'($urandom_range(0, 1));
      bus_if.id_mem_read  = ($urandom_range(0, 2) == 0);
      bus_if.hold         = ($urandom_range(0, 4) == 0);
      bus_if.flush        = ($urandom_range(0, 9) == 0);
      bus_if.fw_mem_rd    = 5'($urandom_range(0, 7));
      bus_if.fw_mem_we    = 1'($urandom_range(0, 1));
      bus_if.fw_mem_data  = $urandom;
      bus_if.fw_wb_rd     = 5'($urandom_range(0, 7));
      bus_if.fw_wb_we     = 1'($urandom_range(0, 1));
      bus_if.fw_wb_data   = $urandom;
      check_all();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and the ALU op field at 5 bits.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge only.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_valid  in  1  decode stage presents an instruction.
REQ-005 id_pc, id_imm, id_csr_data  in  32 each  PC, immediate and CSR read value from decode.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  source and destination register indices.
REQ-007 id_rs1_data, id_rs2_data  in  32 each  register-file read data.
REQ-008 id_alu_op  in  5  ALU operation code; id_b_sel  in  1  (1 = immediate feeds ALU B); id_reg_write, id_mem_read  in  1 each.
REQ-009 hold  in  1  back-end stall (EX, MEM and WB frozen); flush  in  1  wrong-path squash.
REQ-010 fw_mem_rd  in  5, fw_mem_we  in  1, fw_mem_data  in  32  EX/MEM producer.
REQ-011 fw_wb_rd  in  5, fw_wb_we  in  1, fw_wb_data  in  32  MEM/WB producer (same cycle as the register-file write).
REQ-012 ex_valid, ex_reg_write, ex_mem_read  out  1 each; ex_pc, ex_csr_data  out  32 each; ex_rd  out  5; ex_alu_op  out  5.
REQ-013 ex_alu_a, ex_alu_b, ex_store_data  out  32 each  forwarded ALU operands and store data.
REQ-014 id_stall  out  1  instructs decode and fetch to hold.

Function
REQ-015 The stage register SHALL hold valid, pc, imm, csr_data, rs1, rs2, rd, rs1_data, rs2_data, alu_op, b_sel, reg_write and mem_read.
REQ-016 The update priority per edge SHALL be: flush > hold > load-use bubble > load.
REQ-017 On flush, the register SHALL become a bubble regardless of hold: every field 0, with alu_op set to the ALU nop encoding (0).
REQ-018 On hold without flush, every field SHALL keep its value. The exception is the stored rs1_data/rs2_data, which SHALL be replaced by fw_wb_data when fw_wb_we=1, fw_wb_rd!=0 and fw_wb_rd equals the stored rs1/rs2.
REQ-019 The load-use condition SHALL be id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-020 When load-use is true (no flush or hold), the register SHALL load a bubble as in REQ-017.
REQ-021 Otherwise, the register SHALL load all id_* inputs, with ex_valid taking id_valid.
REQ-022 On a normal load, captured rs1_data/rs2_data SHALL take fw_wb_data when fw_wb_we=1, fw_wb_rd!=0 and fw_wb_rd matches id_rs1/id_rs2, covering a write and read of the same register in one cycle.
REQ-023 id_stall SHALL equal hold | load-use, combinationally; load-use stalls SHALL last exactly one cycle.
REQ-024 The forwarded rs1 SHALL select by priority:
- fw_mem_data if fw_mem_we & fw_mem_rd!=0 & fw_mem_rd==rs1;
- else fw_wb_data on the same test with the WB producer;
- else the stored rs1_data.
The forwarded rs2 SHALL use the same priority.
REQ-025 Index 0 SHALL never be forwarded or bypassed.
REQ-026 ex_alu_a SHALL be forwarded rs1; ex_alu_b SHALL be stored imm when b_sel=1, else forwarded rs2; ex_store_data SHALL always be forwarded rs2.
REQ-027 The outputs SHALL be combinational from the register and the fw_* inputs, with zero added latency; instruction latency from id_* to ex_* SHALL be one cycle.
REQ-028 ex_reg_write and ex_mem_read SHALL be 0 whenever ex_valid=0.

Reset
REQ-029 Asserting rst SHALL immediately clear every register field to 0 without waiting for a clock edge, so all outputs read 0 and id_stall reads hold.
REQ-030 After rst deasserts, the first rising edge SHALL perform a normal update.
REQ-031 rst asserted mid-hold or mid-stall SHALL discard the held instruction.

Verification
REQ-032 Load id: rs1=3, rs1_data=5, imm=7, b_sel=1, alu_op=add, rd=4 -> next cycle ex_alu_a=5, ex_alu_b=7, ex_rd=4, ex_valid=1.
REQ-033 EX holds rs1=2 (stored 0x11); drive fw_mem_rd=2, fw_mem_data=0xAA and fw_wb_rd=2, fw_wb_data=0xBB, both with we=1 -> ex_alu_a=0xAA; with fw_mem_we=0 -> 0xBB; with fw_mem_rd=0 and fw_wb_rd=0 -> 0x11.
REQ-034 EX holds a load with rd=5; ID presents rs2=5 -> id_stall=1 for one cycle, a bubble enters (ex_valid=0, ex_reg_write=0), and the ID instruction loads on the following edge.
REQ-035 hold=1 for 3 cycles while fw_wb writes 0x55 to the stored rs1 -> contents otherwise frozen and id_stall=1 throughout; after release ex_alu_a=0x55 with fw inputs idle.
REQ-036 flush and hold together -> ex_valid=0 next edge; rst pulse mid-cycle -> outputs 0 before the next edge.
REQ-037 ID reads x6 while fw_wb writes x6=0x99 in the same cycle -> captured rs1_data=0x99.
